attractor_sweep_ctrl: RTL and testbench
=======================================

// Module: attractor_sweep_ctrl
// PURPOSE
//   Sequences the gene_net datapath for an exhaustive attractor sweep. Seeds every
//   initial state 0..2^N-1 in order, iterates the network one update per clk, and
//   terminates each run on fixed point, cycle, or step limit. Resets the fixed-point
//   and cycle checkers per seed and reports one result per seed over a valid/ready port.
// PARAMETERS
//   N          8    state width (seed count = 2^N)
//   MAX_STEPS  256  max network updates per seed before timeout (>=1)
//   STEP_W     9    step counter width; must hold MAX_STEPS
// PORTS
//   clk          in   1       single clock, all flops rising edge
//   reset        in   1       asynchronous, active-high
//   start        in   1       begin sweep; sampled in IDLE only
//   next_status  in   N       gene_net combinational next state of status
//   is_fixed     in   1       fixed_point_checker result for current next_status
//   is_cycle     in   1       cycle_checker result for current next_status
//   status       out  N       state driven into gene_net
//   chk_reset    out  1       reset to both checkers
//   busy         out  1       high in any state except IDLE
//   done         out  1       one-cycle pulse at sweep end
//   res_valid    out  1       result available
//   res_ready    in   1       consumer accepts result
//   res_init     out  N       seed of this result
//   res_state    out  N       next_status captured at termination
//   res_steps    out  STEP_W  updates performed, 1..MAX_STEPS
//   res_kind     out  2       00 timeout, 01 fixed, 10 cycle, 11 unused
//   cnt_fixed/cnt_cycle/cnt_timeout  out  N+1  sweep totals (see CONFIGURATION)
// BEHAVIOUR
//   Reset: FSM=IDLE; status, res_*, counters=0; busy, done, res_valid=0; chk_reset=1.
//   States: IDLE -> LOAD -> RUN -> REPORT -> (LOAD | DONE) -> IDLE.
//   IDLE: chk_reset=1. start=1 -> seed<=0, go LOAD. start ignored in all other states.
//   LOAD (1 cycle): status<=seed, steps<=0, chk_reset=1 -> RUN.
//   RUN: chk_reset=0. Each cycle status<=next_status, steps<=steps+1. Termination
//     evaluated same cycle on inputs: is_fixed -> kind 01; else is_cycle -> kind 10;
//     else steps+1==MAX_STEPS -> kind 00. On termination capture res_init=seed,
//     res_state=next_status, res_steps=steps+1; go REPORT. Fixed has priority when
//     both flags high.
//   REPORT: res_valid=1; status and payload held stable until res_valid&&res_ready.
//     On handshake: res_valid<=0; seed==2^N-1 -> DONE, else seed<=seed+1 -> LOAD.
//     Ready high before valid: no effect. Min seed latency LOAD->RUN->REPORT = 3 clk.
//   DONE: done=1 for exactly one cycle -> IDLE. busy low the cycle after DONE.
//   Seed increment is N-bit; the 2^N-1 check precedes it, so no wrap is ever taken.
//   Reset asserted mid-sweep: immediate return to reset values; no partial result.
// CONFIGURATION
//   ATTR_HIST_EN defined: cnt_fixed/cnt_cycle/cnt_timeout increment by one on each
//     result handshake per res_kind; cleared at start acceptance in IDLE; hold after
//     DONE; sum == 2^N after full sweep. Width N+1, no saturation needed.
//   ATTR_HIST_EN undefined: counter ports present, tied to 0; no counter flops.
// TESTING
//   1 Identity net (next=status), fixed=1 always, ready=1 -> 256 results, kind 01, steps 1,
//     res_init 0x00..0xFF in order, res_state==res_init, one done pulse.
//   2 Flags tied 0, MAX_STEPS=16 -> every result kind 00, res_steps=16.
//   3 is_fixed and is_cycle both 1 on 3rd RUN cycle -> kind 01, res_steps=3.
//   4 res_ready low 5 cycles in REPORT -> res_valid, payload, status stable; no LOAD.
//   5 reset pulse during RUN of seed 0x42 -> IDLE, res_valid=0, busy=0, chk_reset=1;
//     start during busy ignored (seed sequence not restarted).
//   6 ATTR_HIST_EN, cycle flag on odd seeds, fixed on even -> cnt_fixed=128,
//     cnt_cycle=128, cnt_timeout=0; undefined build -> all counters read 0.

Source files
------------

// File: rtl/attractor_sweep_ctrl.sv
// attractor_sweep_ctrl
//   Sequencer for an exhaustive attractor sweep over a gene_net datapath.
//   Every seed 0..2^N-1 is loaded into the network in order. The network is then
//   iterated one update per clock until it reaches a fixed point, a cycle, or the
//   step limit. One result per seed is offered on a valid/ready port.
//
//   Optional feature macro: ATTR_HIST_EN
//     defined   : per-kind result counters (cnt_fixed/cnt_cycle/cnt_timeout) are
//                 kept for the current sweep.
//     undefined : counter ports exist but are tied to zero, and no counter flops
//                 are built.
module attractor_sweep_ctrl #(
    parameter int N         = 8,
    parameter int MAX_STEPS = 256,
    parameter int STEP_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      next_status,
    input  logic              is_fixed,
    input  logic              is_cycle,
    output logic [N-1:0]      status,
    output logic              chk_reset,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_init,
    output logic [N-1:0]      res_state,
    output logic [STEP_W-1:0] res_steps,
    output logic [1:0]        res_kind,
    output logic [N:0]        cnt_fixed,
    output logic [N:0]        cnt_cycle,
    output logic [N:0]        cnt_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] KIND_TIMEOUT = 2'b00;
    localparam logic [1:0] KIND_FIXED   = 2'b01;
    localparam logic [1:0] KIND_CYCLE   = 2'b10;

    localparam logic [N-1:0]      SEED_LAST = {N{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);

    state_t              state_r;
    logic [N-1:0]        seed_r;
    logic [STEP_W-1:0]   steps_r;

    // Number of updates completed once the current RUN cycle has finished.
    logic [STEP_W-1:0]   steps_inc_s;
    logic                last_step_s;
    logic                handshake_s;

    assign steps_inc_s = steps_r + STEP_ONE;
    assign last_step_s = (steps_inc_s == STEP_MAX);
    assign handshake_s = (state_r == ST_REPORT) && res_valid && res_ready;

    // Sweep sequencer: seed loading, iteration, termination and result hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            seed_r    <= '0;
            steps_r   <= '0;
            status    <= '0;
            chk_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_init  <= '0;
            res_state <= '0;
            res_steps <= '0;
            res_kind  <= KIND_TIMEOUT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    chk_reset <= 1'b1;
                    done      <= 1'b0;
                    if (start) begin
                        seed_r  <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Checkers have been held in reset for this cycle; release them
                    // together with the first iteration.
                    status    <= seed_r;
                    steps_r   <= '0;
                    chk_reset <= 1'b0;
                    state_r   <= ST_RUN;
                end
                ST_RUN: begin
                    status  <= next_status;
                    steps_r <= steps_inc_s;
                    if (is_fixed || is_cycle || last_step_s) begin
                        res_init  <= seed_r;
                        res_state <= next_status;
                        res_steps <= steps_inc_s;
                        if (is_fixed) begin
                            res_kind <= KIND_FIXED;
                        end else if (is_cycle) begin
                            res_kind <= KIND_CYCLE;
                        end else begin
                            res_kind <= KIND_TIMEOUT;
                        end
                        res_valid <= 1'b1;
                        chk_reset <= 1'b1;
                        state_r   <= ST_REPORT;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end
                ST_REPORT: begin
                    // status and payload stay frozen until the consumer takes the result.
                    if (handshake_s) begin
                        res_valid <= 1'b0;
                        if (seed_r == SEED_LAST) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            seed_r  <= seed_r + {{(N-1){1'b0}}, 1'b1};
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    chk_reset <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ATTR_HIST_EN
    localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};

    logic start_acc_s;
    assign start_acc_s = (state_r == ST_IDLE) && start;

    // Per-kind result histogram: cleared when a sweep is accepted, bumped per handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_fixed   <= '0;
            cnt_cycle   <= '0;
            cnt_timeout <= '0;
        end else if (start_acc_s) begin
            cnt_fixed   <= '0;
            cnt_cycle   <= '0;
            cnt_timeout <= '0;
        end else if (handshake_s) begin
            case (res_kind)
                KIND_FIXED:   cnt_fixed   <= cnt_fixed + CNT_ONE;
                KIND_CYCLE:   cnt_cycle   <= cnt_cycle + CNT_ONE;
                KIND_TIMEOUT: cnt_timeout <= cnt_timeout + CNT_ONE;
                default:      cnt_timeout <= cnt_timeout;
            endcase
        end else begin
            cnt_fixed   <= cnt_fixed;
            cnt_cycle   <= cnt_cycle;
            cnt_timeout <= cnt_timeout;
        end
    end
`else
    assign cnt_fixed   = '0;
    assign cnt_cycle   = '0;
    assign cnt_timeout = '0;
`endif

endmodule

// File: tb/tb_attractor_sweep_ctrl.sv
// Self-checking bench for attractor_sweep_ctrl.
// A behavioural gene_net plus checker model drives the DUT. Expected results per
// seed are computed up front by walking each trajectory directly. Counter
// expectations follow ATTR_HIST_EN.
module tb_attractor_sweep_ctrl;

    localparam int N      = 8;
    localparam int MAXS   = 16;
    localparam int SW     = 9;
    localparam int NSEEDS = 256;

    // Network/checker behaviour modes
    localparam int M_ID_FIX   = 0;  // identity, fixed always
    localparam int M_RND_NONE = 1;  // random map, flags never
    localparam int M_RND_CHK  = 2;  // random map, real fixed/cycle detection
    localparam int M_RND_BOTH = 3;  // random map, both flags on 3rd RUN cycle
    localparam int M_ID_PAR   = 4;  // identity, fixed on even, cycle on odd
    localparam int M_ID_NONE  = 5;  // identity, flags never

    typedef struct {
        logic [7:0] init;
        logic [7:0] state;
        logic [8:0] steps;
        logic [1:0] kind;
    } res_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [N-1:0]  next_status;
    logic          is_fixed;
    logic          is_cycle;
    logic [N-1:0]  status;
    logic          chk_reset;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_init;
    logic [N-1:0]  res_state;
    logic [SW-1:0] res_steps;
    logic [1:0]    res_kind;
    logic [N:0]    cnt_fixed;
    logic [N:0]    cnt_cycle;
    logic [N:0]    cnt_timeout;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   gtab [NSEEDS];
    int           mode       = M_ID_FIX;
    int           ready_mode = 0;
    int           hold_left  = 5;
    logic [255:0] hist;
    int           run_cyc;
    res_t         exp_q [$];
    int           done_cnt = 0;
    int           cyc_n    = 0;
    int           last_hs  = -1;
    int           exp_f, exp_c, exp_t;

    attractor_sweep_ctrl #(.N(N), .MAX_STEPS(MAXS), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .next_status(next_status), .is_fixed(is_fixed), .is_cycle(is_cycle),
        .status(status), .chk_reset(chk_reset), .busy(busy), .done(done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_state(res_state), .res_steps(res_steps),
        .res_kind(res_kind),
        .cnt_fixed(cnt_fixed), .cnt_cycle(cnt_cycle), .cnt_timeout(cnt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // gene_net and checker stand-in
    always_comb begin
        next_status = status;
        is_fixed    = 1'b0;
        is_cycle    = 1'b0;
        case (mode)
            M_ID_FIX: begin next_status = status; is_fixed = 1'b1; end
            M_RND_NONE: next_status = gtab[status];
            M_RND_CHK: begin
                next_status = gtab[status];
                is_fixed    = (next_status == status);
                is_cycle    = hist[next_status] || (next_status == status);
            end
            M_RND_BOTH: begin
                next_status = gtab[status];
                is_fixed    = (run_cyc == 2);
                is_cycle    = (run_cyc == 2);
            end
            M_ID_PAR: begin is_fixed = ~status[0]; is_cycle = status[0]; end
            default: next_status = status;
        endcase
    end

    // checker history: states visited since the checkers were last reset
    always @(posedge clk) begin
        if (chk_reset) begin
            hist    <= '0;
            run_cyc <= 0;
        end else begin
            hist[status] <= 1'b1;
            run_cyc      <= run_cyc + 1;
        end
    end

    // Reference: walk the trajectory from seed s
    function automatic res_t ref_res(input int s, input int m);
        bit   seen [NSEEDS];
        int   x, nx;
        bit   f, c;
        res_t r;
        foreach (seen[i]) seen[i] = 1'b0;
        x = s;
        seen[s] = 1'b1;
        r.init = 8'(s); r.state = 8'd0; r.steps = 9'd0; r.kind = 2'd3;
        for (int k = 1; k <= MAXS; k++) begin
            nx = (m == M_ID_FIX || m == M_ID_PAR || m == M_ID_NONE) ? x : int'(gtab[x]);
            f = 1'b0; c = 1'b0;
            case (m)
                M_ID_FIX:   f = 1'b1;
                M_RND_CHK:  begin f = (nx == x); c = seen[nx]; end
                M_RND_BOTH: begin f = (k == 3); c = (k == 3); end
                M_ID_PAR:   begin f = (x % 2 == 0); c = (x % 2 == 1); end
                default:    begin f = 1'b0; c = 1'b0; end
            endcase
            if (f || c || k == MAXS) begin
                r.state = 8'(nx);
                r.steps = 9'(k);
                r.kind  = f ? 2'b01 : (c ? 2'b10 : 2'b00);
                return r;
            end
            seen[nx] = 1'b1;
            x = nx;
        end
        return r;
    endfunction

    // Consumer + scoreboard: chooses ready each cycle and checks offered results
    initial begin
        res_t e;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (done) done_cnt++;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (res_valid && hold_left > 0) begin
                        res_ready = 1'b0;
                        hold_left--;
                    end else begin
                        res_ready = 1'b1;
                        if (res_valid) hold_left = 5;
                    end
                end
            endcase
            if (res_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    check_eq("res_extra", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (res_ready) begin
                        check_eq("res_init", 32'(res_init), 32'(e.init));
                        check_eq("res_state", 32'(res_state), 32'(e.state));
                        check_eq("res_steps", 32'(res_steps), 32'(e.steps));
                        check_eq("res_kind", 32'(res_kind), 32'(e.kind));
                        if (mode == M_ID_FIX && ready_mode == 0 && last_hs >= 0)
                            check_eq("seed_latency", 32'(cyc_n - last_hs), 32'd3);
                        last_hs = cyc_n;
                        void'(exp_q.pop_front());
                    end else if (ready_mode == 2) begin
                        check_eq("hold_init", 32'(res_init), 32'(e.init));
                        check_eq("hold_state", 32'(res_state), 32'(e.state));
                        check_eq("hold_status", 32'(status), 32'(e.state));
                    end
                end
            end
        end
    end

    task automatic load_expect(input int m);
        res_t r;
        exp_q.delete();
        exp_f = 0; exp_c = 0; exp_t = 0;
        for (int s = 0; s < NSEEDS; s++) begin
            r = ref_res(s, m);
            exp_q.push_back(r);
            if (r.kind == 2'b01) exp_f++;
            else if (r.kind == 2'b10) exp_c++;
            else exp_t++;
        end
    endtask

    task automatic run_sweep(input int m, input int rm, input bit poke_start);
        bit seen_done;
        mode = m; ready_mode = rm; hold_left = 5; last_hs = -1;
        load_expect(m);
        @(negedge clk);
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (poke_start && cyc == 100) start = 1'b1;
            if (poke_start && cyc == 101) start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        check_eq("sweep_done_seen", 32'(seen_done), 32'd1);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("results_left", 32'(exp_q.size()), 32'd0);
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge clk);
`ifdef ATTR_HIST_EN
        check_eq("cnt_fixed", 32'(cnt_fixed), 32'(exp_f));
        check_eq("cnt_cycle", 32'(cnt_cycle), 32'(exp_c));
        check_eq("cnt_timeout", 32'(cnt_timeout), 32'(exp_t));
`else
        check_eq("cnt_fixed", 32'(cnt_fixed), 32'd0);
        check_eq("cnt_cycle", 32'(cnt_cycle), 32'd0);
        check_eq("cnt_timeout", 32'(cnt_timeout), 32'd0);
`endif
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NSEEDS; i++) begin
            gtab[i] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) gtab[i] = 8'(i);
        end
        repeat (3) @(negedge clk);
        check_eq("rst_status", 32'(status), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_chk_reset", 32'(chk_reset), 32'd1);
        check_eq("rst_payload", 32'({res_init, res_state, res_steps, res_kind}), 32'd0);
        check_eq("rst_cnts", 32'({cnt_fixed, cnt_cycle, cnt_timeout}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(M_ID_FIX, 0, 1'b0);     // identity, fixed -> kind 01 steps 1, in order
        run_sweep(M_RND_NONE, 1, 1'b1);   // timeout on every seed, start poked mid-sweep
        run_sweep(M_RND_BOTH, 1, 1'b0);   // both flags at 3rd RUN cycle
        run_sweep(M_RND_CHK, 2, 1'b0);    // real detection, ready held low 5 cycles

        // reset during RUN of seed 0x42
        mode = M_ID_NONE; ready_mode = 0;
        load_expect(M_ID_NONE);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 5000 && !hit; cyc++) begin
            @(negedge clk);
            if (busy && !chk_reset && status == 8'h42) begin
                hit = 1'b1;
                reset = 1'b1;
            end
        end
        check_eq("reach_seed_42", 32'(hit), 32'd1);
        #1;
        exp_q.delete();
        check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_chk_reset", 32'(chk_reset), 32'd1);
        check_eq("mid_rst_status", 32'(status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_idle", 32'({busy, res_valid, done}), 32'd0);

        run_sweep(M_ID_PAR, 1, 1'b0);     // 128 fixed / 128 cycle / 0 timeout

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
